// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC and stall/flush controller for a 5-stage pipeline.
// Chooses the next PC (sequential, branch target or hold) and handles
// load-use stalls, memory-wait freezes, and a HALT that drains the pipe
// before raising Halt. Resume returns to RUN.
// Optional feature: define PC_SEQ_PERF_EN to add the StallCnt/FlushCnt
// saturating performance counters.
module pc_sequencer #(
  parameter int                ADDR_W       = 16,
  parameter int                PC_INC       = 2,
  parameter logic [ADDR_W-1:0] RESET_VEC    = '0,
  parameter int                DRAIN_CYCLES = 4,
  parameter int                MAX_STALL    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PC,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              LoadUse,
  input  logic              HaltDec,
  input  logic              MemWait,
  input  logic              Resume,
  output logic [ADDR_W-1:0] NewPC,
  output logic              StopPC,
  output logic              Halt,
  output logic              IFIDFlush,
  output logic              IDEXBubble,
  output logic              StallErr,
  output logic [1:0]        State
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [15:0]       StallCnt,
  output logic [15:0]       FlushCnt
`endif
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int SW = $clog2(MAX_STALL + 1);

  // drain_cnt starts one below DRAIN_CYCLES because HALTED is entered on
  // the edge that ends the cycle in which drain_cnt is already zero.
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
  // The wait cycle that sees this value is the MAX_STALL-th in a row.
  localparam logic [SW-1:0] STALL_LAST = SW'(MAX_STALL - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_DRAIN  = 2'b01,
    S_HALTED = 2'b10
  } state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   drain_cnt_reg, drain_cnt_next;
  logic [SW-1:0]   stall_cnt_reg, stall_cnt_next;
  logic            err_reg, err_next;

  // State and counter registers; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_RUN;
      drain_cnt_reg <= '0;
      stall_cnt_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      stall_cnt_reg <= stall_cnt_next;
      err_reg       <= err_next;
    end
  end

  // Next-state and PC-control outputs, combinational from state + inputs.
  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    stall_cnt_next = '0;          // any cycle without MemWait clears it
    err_next       = err_reg;
    NewPC          = PC;
    StopPC         = 1'b1;
    Halt           = 1'b0;
    IFIDFlush      = 1'b0;
    IDEXBubble     = 1'b0;

    if (rst) begin
      NewPC  = RESET_VEC;
      StopPC = 1'b0;
    end else begin
      unique case (state_reg)
        S_RUN: begin
          if (MemWait) begin
            // Whole pipe frozen: hazards are re-evaluated after release.
            if (stall_cnt_reg == STALL_LAST) begin
              err_next   = 1'b1;
              state_next = S_HALTED;
            end else begin
              stall_cnt_next = stall_cnt_reg + SW'(1);
            end
          end else if (BranchTaken) begin
            // Younger HALT/load-use are on the wrong path and get squashed.
            NewPC      = BranchTarget;
            StopPC     = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
          end else if (HaltDec) begin
            IFIDFlush      = 1'b1;
            drain_cnt_next = DRAIN_INIT;
            state_next     = S_DRAIN;
          end else if (LoadUse) begin
            IDEXBubble = 1'b1;
          end else begin
            NewPC  = PC + ADDR_W'(PC_INC);
            StopPC = 1'b0;
          end
        end

        S_DRAIN: begin
          IFIDFlush = 1'b1;
          if (MemWait) begin
            // Drain is frozen with the pipe, but the timeout keeps running.
            if (stall_cnt_reg == STALL_LAST) begin
              err_next   = 1'b1;
              state_next = S_HALTED;
            end else begin
              stall_cnt_next = stall_cnt_reg + SW'(1);
            end
          end else if (drain_cnt_reg == '0) begin
            state_next = S_HALTED;
          end else begin
            drain_cnt_next = drain_cnt_reg - DW'(1);
          end
        end

        S_HALTED: begin
          Halt = 1'b1;
          if (Resume) begin
            state_next = S_RUN;
            err_next   = 1'b0;
          end
        end

        default: begin
          state_next = S_RUN;
        end
      endcase
    end
  end

  assign State    = state_reg;
  assign StallErr = err_reg;

`ifdef PC_SEQ_PERF_EN
  logic        stall_evt;
  logic        flush_evt;
  logic [15:0] stall_perf_reg;
  logic [15:0] flush_perf_reg;

  // A RUN cycle that holds the PC counts as a stall; only branches that
  // win arbitration (no MemWait) count as flushes.
  assign stall_evt = !rst && (state_reg == S_RUN) && StopPC;
  assign flush_evt = !rst && (state_reg == S_RUN) && !MemWait && BranchTaken;

  // Saturating 16-bit performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_perf_reg <= '0;
      flush_perf_reg <= '0;
    end else begin
      if (stall_evt && (stall_perf_reg != 16'hFFFF))
        stall_perf_reg <= stall_perf_reg + 16'd1;
      if (flush_evt && (flush_perf_reg != 16'hFFFF))
        flush_perf_reg <= flush_perf_reg + 16'd1;
    end
  end

  assign StallCnt = stall_perf_reg;
  assign FlushCnt = flush_perf_reg;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized stimulus against a
// cycle-level behavioural model of the PC sequencer.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] PC;
  logic        BranchTaken;
  logic [15:0] BranchTarget;
  logic        LoadUse;
  logic        HaltDec;
  logic        MemWait;
  logic        Resume;
  logic [15:0] NewPC;
  logic        StopPC;
  logic        Halt;
  logic        IFIDFlush;
  logic        IDEXBubble;
  logic        StallErr;
  logic [1:0]  State;
`ifdef PC_SEQ_PERF_EN
  logic [15:0] StallCnt;
  logic [15:0] FlushCnt;
`endif

  int checks   = 0;
  int failures = 0;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .PC           (PC),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .LoadUse      (LoadUse),
    .HaltDec      (HaltDec),
    .MemWait      (MemWait),
    .Resume       (Resume),
    .NewPC        (NewPC),
    .StopPC       (StopPC),
    .Halt         (Halt),
    .IFIDFlush    (IFIDFlush),
    .IDEXBubble   (IDEXBubble),
    .StallErr     (StallErr),
    .State        (State)
`ifdef PC_SEQ_PERF_EN
    ,
    .StallCnt     (StallCnt),
    .FlushCnt     (FlushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int M_RUN    = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_HALTED = 2;

  int  m_mode;
  int  m_drain_left;   // DRAIN cycles still to pass (unfrozen)
  int  m_waits;        // consecutive MemWait cycles so far
  bit  m_err;
  int  m_stalls;
  int  m_flushes;

  logic [15:0] e_newpc;
  logic        e_stop, e_halt, e_flush, e_bubble;

  // Expected combinational outputs for the current inputs.
  function automatic void model_eval();
    e_newpc  = PC;
    e_stop   = 1'b1;
    e_halt   = 1'b0;
    e_flush  = 1'b0;
    e_bubble = 1'b0;
    if (rst) begin
      e_newpc = 16'h0000;
      e_stop  = 1'b0;
    end else if (m_mode == M_HALTED) begin
      e_halt = 1'b1;
    end else if (m_mode == M_DRAIN) begin
      e_flush = 1'b1;
    end else if (MemWait) begin
      e_stop = 1'b1;
    end else if (BranchTaken) begin
      e_newpc  = BranchTarget;
      e_stop   = 1'b0;
      e_flush  = 1'b1;
      e_bubble = 1'b1;
    end else if (HaltDec) begin
      e_flush = 1'b1;
    end else if (LoadUse) begin
      e_bubble = 1'b1;
    end else begin
      e_newpc = 16'((int'(PC) + 2) % 65536);
      e_stop  = 1'b0;
    end
  endfunction

  // Advance the model across one clock edge.
  function automatic void model_advance();
    if (rst) begin
      m_mode = M_RUN; m_drain_left = 0; m_waits = 0; m_err = 0;
      m_stalls = 0; m_flushes = 0;
    end else if (m_mode == M_HALTED) begin
      m_waits = 0;
      if (Resume) begin
        m_mode = M_RUN;
        m_err  = 0;
      end
    end else if (MemWait) begin
      if (m_mode == M_RUN && m_stalls < 65535) m_stalls++;
      m_waits++;
      if (m_waits >= 8) begin
        m_err   = 1;
        m_mode  = M_HALTED;
        m_waits = 0;
      end
    end else begin
      m_waits = 0;
      if (m_mode == M_DRAIN) begin
        m_drain_left--;
        if (m_drain_left == 0) m_mode = M_HALTED;
      end else if (BranchTaken) begin
        if (m_flushes < 65535) m_flushes++;
      end else if (HaltDec) begin
        if (m_stalls < 65535) m_stalls++;
        m_mode       = M_DRAIN;
        m_drain_left = 4;
      end else if (LoadUse) begin
        if (m_stalls < 65535) m_stalls++;
      end
    end
  endfunction

  task automatic clear_inputs();
    rst = 1'b0; BranchTaken = 1'b0; BranchTarget = 16'h0000;
    LoadUse = 1'b0; HaltDec = 1'b0; MemWait = 1'b0; Resume = 1'b0;
  endtask

  // Inputs are driven at posedge+1, outputs sampled at negedge.
  task automatic settle();
    #4;
    model_eval();
  endtask

  task automatic advance();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      rst = 1'b1; PC = 16'h1234; BranchTaken = 1'b1; BranchTarget = 16'h0ABC;
      settle();
      checks++;
      if ({NewPC, StopPC, Halt, IFIDFlush, IDEXBubble} !== {16'h0000, 4'b0000}) begin
        failures++;
        $display("FAIL reset_out got=%h/%b%b%b%b want=0000/0000", NewPC, StopPC, Halt, IFIDFlush, IDEXBubble);
      end
      $display("txn reset cycle %0d NewPC=%h", c, NewPC);
      advance();
    end
    clear_inputs();
    PC = 16'h1234;
    checks++;
    if ({State, StallErr} !== 3'b000) begin
      failures++;
      $display("FAIL reset_state got=%b/%b want=00/0", State, StallErr);
    end
    advance();
  endtask

  task automatic test_sequential();
    logic [15:0] pcs  [2];
    logic [15:0] want [2];
    pcs[0] = 16'h0010; want[0] = 16'h0012;
    pcs[1] = 16'hFFFE; want[1] = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      clear_inputs();
      PC = pcs[i];
      settle();
      checks++;
      if ({NewPC, StopPC, IFIDFlush, IDEXBubble} !== {want[i], 3'b000}) begin
        failures++;
        $display("FAIL seq_pc pc=%h got=%h/%b want=%h/0", PC, NewPC, StopPC, want[i]);
      end
      $display("txn seq PC=%h NewPC=%h", PC, NewPC);
      advance();
    end
  endtask

  task automatic test_branch_priority();
    clear_inputs();
    PC = 16'h0050; BranchTaken = 1'b1; HaltDec = 1'b1; LoadUse = 1'b1;
    BranchTarget = 16'h0100;
    settle();
    checks++;
    if ({NewPC, StopPC, IFIDFlush, IDEXBubble} !== {16'h0100, 3'b011}) begin
      failures++;
      $display("FAIL branch_prio got=%h/%b%b%b want=0100/011", NewPC, StopPC, IFIDFlush, IDEXBubble);
    end
    $display("txn branch NewPC=%h", NewPC);
    advance();
    clear_inputs();
    checks++;
    if (State !== 2'b00) begin
      failures++;
      $display("FAIL branch_state got=%b want=00", State);
    end
  endtask

  task automatic test_halt_drain(input bit with_wait, input int exp_edges);
    int edges;
    edges = 0;
    clear_inputs();
    PC = 16'h0020; HaltDec = 1'b1; LoadUse = 1'b1;
    settle();
    checks++;
    if ({NewPC, StopPC, IFIDFlush} !== {16'h0020, 2'b11}) begin
      failures++;
      $display("FAIL halt_dec got=%h/%b%b want=0020/11", NewPC, StopPC, IFIDFlush);
    end
    advance();
    checks++;
    if (State !== 2'b01) begin
      failures++;
      $display("FAIL drain_state got=%b want=01", State);
    end
    for (int i = 1; i <= 20; i++) begin
      // Wrong-path noise during drain must be ignored.
      BranchTaken = 1'b1; BranchTarget = 16'h0BAD; LoadUse = 1'b1;
      HaltDec = (i == 1);
      MemWait = with_wait && (i == 2 || i == 3);
      settle();
      checks++;
      if ({NewPC, StopPC, Halt, IFIDFlush, IDEXBubble} !== {e_newpc, e_stop, e_halt, e_flush, e_bubble}) begin
        failures++;
        $display("FAIL drain_out i=%0d got=%h/%b%b%b%b want=%h/%b%b%b%b", i, NewPC, StopPC, Halt,
                 IFIDFlush, IDEXBubble, e_newpc, e_stop, e_halt, e_flush, e_bubble);
      end
      advance();
      if (Halt === 1'b1) begin
        edges = i;
        break;
      end
    end
    clear_inputs();
    $display("txn drain wait=%0d edges=%0d", with_wait, edges);
    checks++;
    if (edges != exp_edges) begin
      failures++;
      $display("FAIL drain_edges got=%0d want=%0d", edges, exp_edges);
    end
    checks++;
    if ({State, StallErr} !== 3'b100) begin
      failures++;
      $display("FAIL halted_state got=%b/%b want=10/0", State, StallErr);
    end
  endtask

  task automatic test_resume();
    clear_inputs();
    PC = 16'h0020; BranchTaken = 1'b1; BranchTarget = 16'h0300;
    settle();
    checks++;
    if ({NewPC, StopPC, Halt} !== {16'h0020, 2'b11}) begin
      failures++;
      $display("FAIL halted_hold got=%h/%b%b want=0020/11", NewPC, StopPC, Halt);
    end
    advance();
    clear_inputs();
    Resume = 1'b1;
    settle();
    checks++;
    if (Halt !== 1'b1) begin
      failures++;
      $display("FAIL resume_same_cycle got=%b want=1", Halt);
    end
    advance();
    clear_inputs();
    settle();
    checks++;
    if ({NewPC, StopPC, Halt, State} !== {16'h0022, 2'b00, 2'b00}) begin
      failures++;
      $display("FAIL resume_run got=%h/%b%b/%b want=0022/00/00", NewPC, StopPC, Halt, State);
    end
    $display("txn resume NewPC=%h", NewPC);
    advance();
  endtask

  task automatic test_stall_timeout();
    // Seven waits, one release, seven waits: release clears the count.
    for (int i = 1; i <= 15; i++) begin
      clear_inputs();
      PC = 16'h0040;
      MemWait = (i != 8);
      settle();
      advance();
    end
    checks++;
    if ({State, StallErr} !== 3'b000) begin
      failures++;
      $display("FAIL stall_release got=%b/%b want=00/0", State, StallErr);
    end
    clear_inputs();
    settle();
    advance();
    for (int i = 1; i <= 8; i++) begin
      clear_inputs();
      PC = 16'h0040; MemWait = 1'b1; BranchTaken = 1'b1; LoadUse = 1'b1;
      BranchTarget = 16'h0400;
      settle();
      checks++;
      if ({NewPC, StopPC, IFIDFlush, IDEXBubble} !== {16'h0040, 3'b100}) begin
        failures++;
        $display("FAIL memwait_out i=%0d got=%h/%b%b%b want=0040/100", i, NewPC, StopPC, IFIDFlush, IDEXBubble);
      end
      advance();
      if (i == 7) begin
        checks++;
        if ({State, StallErr} !== 3'b000) begin
          failures++;
          $display("FAIL stall_early got=%b/%b want=00/0", State, StallErr);
        end
      end
    end
    clear_inputs();
    $display("txn timeout State=%b StallErr=%b Halt=%b", State, StallErr, Halt);
    checks++;
    if ({State, StallErr, Halt} !== 4'b1011) begin
      failures++;
      $display("FAIL stall_timeout got=%b/%b/%b want=10/1/1", State, StallErr, Halt);
    end
  endtask

  task automatic test_reset_mid_drain();
    // Reset out of HALTED with StallErr set.
    clear_inputs();
    rst = 1'b1; PC = 16'h0040;
    settle();
    checks++;
    if ({NewPC, StopPC, Halt} !== {16'h0000, 2'b00}) begin
      failures++;
      $display("FAIL rst_halted got=%h/%b%b want=0000/00", NewPC, StopPC, Halt);
    end
    advance();
    clear_inputs();
    checks++;
    if ({State, StallErr} !== 3'b000) begin
      failures++;
      $display("FAIL rst_clears_err got=%b/%b want=00/0", State, StallErr);
    end
    // Reset in the middle of a drain.
    PC = 16'h0060; HaltDec = 1'b1;
    settle();
    advance();
    clear_inputs();
    settle();
    advance();
    rst = 1'b1;
    settle();
    checks++;
    if ({NewPC, StopPC, Halt, IFIDFlush, IDEXBubble} !== {16'h0000, 4'b0000}) begin
      failures++;
      $display("FAIL rst_drain_out got=%h/%b%b%b%b want=0000/0000", NewPC, StopPC, Halt, IFIDFlush, IDEXBubble);
    end
    advance();
    clear_inputs();
    $display("txn rst_mid_drain State=%b", State);
    checks++;
    if ({State, StallErr} !== 3'b000) begin
      failures++;
      $display("FAIL rst_drain_state got=%b/%b want=00/0", State, StallErr);
    end
  endtask

  task automatic test_random();
    int burst;
    burst = 0;
    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      if (burst == 0 && $urandom_range(0, 24) == 0) burst = $urandom_range(5, 10);
      rst          = ($urandom_range(0, 59) == 0);
      PC           = 16'($urandom_range(0, 32767) * 2);
      BranchTaken  = ($urandom_range(0, 3) == 0);
      BranchTarget = 16'($urandom_range(0, 65535));
      LoadUse      = ($urandom_range(0, 3) == 0);
      HaltDec      = ($urandom_range(0, 9) == 0);
      MemWait      = (burst > 0) || ($urandom_range(0, 5) == 0);
      Resume       = ($urandom_range(0, 2) == 0);
      if (burst > 0) burst--;
      settle();
      checks++;
      if ({NewPC, StopPC, Halt, IFIDFlush, IDEXBubble} !== {e_newpc, e_stop, e_halt, e_flush, e_bubble}) begin
        failures++;
        $display("FAIL rnd_out n=%0d got=%h/%b%b%b%b want=%h/%b%b%b%b", n, NewPC, StopPC, Halt,
                 IFIDFlush, IDEXBubble, e_newpc, e_stop, e_halt, e_flush, e_bubble);
      end
      advance();
      checks++;
      if ({State, StallErr} !== {2'(m_mode), m_err}) begin
        failures++;
        $display("FAIL rnd_state n=%0d got=%b/%b want=%b/%b", n, State, StallErr, 2'(m_mode), m_err);
      end
`ifdef PC_SEQ_PERF_EN
      checks++;
      if ({StallCnt, FlushCnt} !== {16'(m_stalls), 16'(m_flushes)}) begin
        failures++;
        $display("FAIL rnd_perf n=%0d got=%0d/%0d want=%0d/%0d", n, StallCnt, FlushCnt, m_stalls, m_flushes);
      end
`endif
      $display("txn rnd %0d NewPC=%h State=%b", n, NewPC, State);
    end
    clear_inputs();
  endtask

`ifdef PC_SEQ_PERF_EN
  task automatic test_perf();
    clear_inputs();
    rst = 1'b1;
    settle();
    advance();
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      PC = 16'h0080; LoadUse = 1'b1;
      settle();
      advance();
    end
    clear_inputs();
    PC = 16'h0080; BranchTaken = 1'b1; BranchTarget = 16'h0200;
    settle();
    advance();
    clear_inputs();
    $display("txn perf StallCnt=%0d FlushCnt=%0d", StallCnt, FlushCnt);
    checks++;
    if ({StallCnt, FlushCnt} !== {16'd3, 16'd1}) begin
      failures++;
      $display("FAIL perf_counts got=%0d/%0d want=3/1", StallCnt, FlushCnt);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b1;
    PC  = 16'h1234;
    m_mode = M_RUN; m_drain_left = 0; m_waits = 0; m_err = 0;
    m_stalls = 0; m_flushes = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_branch_priority();
    test_halt_drain(1'b0, 4);
    test_resume();
    test_halt_drain(1'b1, 6);
    test_resume();
    test_stall_timeout();
    test_reset_mid_drain();
`ifdef PC_SEQ_PERF_EN
    test_perf();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
